systemizer_mem: RTL and testbench
=================================

Name: systemizer_mem

Overview:
- Responder end of the systemizer's matrix memory interface: a single-clock word RAM that serves `rd_en`/`rd_addr` → `data_out` and `wr_en`/`wr_addr`/`data_in`.
- Adds a host-side streaming loader/unloader and a run sequencer, so the Tiny Tapeout top can load a matrix, run the systemizer, then read the result back.
- Sits beside the systemizer instance in the top-level wrapper.

Parameters:
- DATA_W, 4, word width in bits (equals systemizer BLOCK).
- DEPTH, 20, number of words (L*K/BLOCK for L=8, K=10).
- ADDR_W, 5, address width, at least clog2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rd_en  in  1  engine read request.
- rd_addr  in  ADDR_W  engine read address.
- data_out  out  DATA_W  engine read data, 1-cycle latency.
- wr_en  in  1  engine write strobe.
- wr_addr  in  ADDR_W  engine write address.
- data_in  in  DATA_W  engine write data.
- eng_start  out  1  one-cycle start pulse to the systemizer.
- eng_done  in  1  systemizer done pulse.
- host_load  in  1  pulse: begin load of DEPTH words.
- host_wdata  in  DATA_W  load word.
- host_wvalid  in  1  load word valid; always accepted while in LOAD.
- host_run  in  1  pulse: start engine.
- host_unload  in  1  pulse: begin unload of DEPTH words.
- host_rdata  out  DATA_W  unload word.
- host_rvalid  out  1  unload word valid.
- host_rready  in  1  host accepts unload word.
- busy  out  1  state is not IDLE.
- acc_err  out  1  sticky: engine access attempted outside RUN.

Behaviour:
- **Reset values.** Reset forces:
  - state IDLE;
  - `data_out`=0, `host_rdata`=0, `host_rvalid`=0, `eng_start`=0, `busy`=0, `acc_err`=0;
  - address counter cleared.
  - RAM contents are not reset.
- **FSM states.** IDLE, LOAD, RUN, UNLOAD.
- **IDLE.**
  - `host_load` → LOAD, counter=0.
  - `host_run` → RUN, with `eng_start` high for exactly the next cycle.
  - `host_unload` → UNLOAD, counter=0.
  - Priority when pulses coincide: load > run > unload.
  - Command pulses outside IDLE are ignored.
- **LOAD.**
  - Each cycle with `host_wvalid` writes `host_wdata` to RAM[counter] and increments the counter.
  - After the write at counter=DEPTH-1 → IDLE, counter=0. No wrap.
- **RUN.**
  - Engine owns the RAM.
  - Read: `rd_en` at cycle t → `data_out` = RAM[`rd_addr`] at t+1.
  - `data_out` holds its last value when `rd_en` is low.
  - Write: `wr_en` writes `data_in` to RAM[`wr_addr`].
  - Read and write to the same address in the same cycle return the new data (write-first).
  - `eng_done` → IDLE.
- **Engine accesses outside RUN.** Dropped: no RAM change, `data_out` holds. `acc_err` is set and stays set until reset.
- **Addresses ≥ DEPTH.** In any state: writes are dropped, reads return 0, `acc_err` is set.
- **UNLOAD.**
  - Streams RAM[0..DEPTH-1] in order on `host_rdata`/`host_rvalid`.
  - The first word is valid 2 cycles after entry.
  - Valid/ready: a word transfers on a cycle with `host_rvalid` & `host_rready`.
  - `host_rdata` and `host_rvalid` are stable while `host_rvalid` & !`host_rready`.
  - Full throughput: with `host_rready` held high, one word per cycle, no bubbles. This needs a 1-entry prefetch/skid register.
  - After word DEPTH-1 transfers: `host_rvalid`=0 the next cycle, → IDLE.
- **Reset mid-operation.** Any state → IDLE immediately. A partial load leaves the words already written in RAM.

Optional Feature:
- Macro: SYSTEMIZER_MEM_PARITY_EN.
- With the macro defined:
  - each word stores an extra even-parity bit, computed on every write (host and engine);
  - parity is checked on every engine read and every unload read;
  - a mismatch sets the sticky output `par_err`, which is cleared only by reset.
- Without the macro: no parity storage, and `par_err` is tied to 0 (port still present).

Decomposition:
- Shared package `systemizer_pkg`:
  - state enum `mem_state_t` {IDLE, LOAD, RUN, UNLOAD};
  - default DATA_W/DEPTH/ADDR_W constants;
  - a parity function.
- One sub-module `systemizer_ram`:
  - single-clock RAM, one synchronous read port and one write port, write-first;
  - instantiated once and muxed between engine and host ports by state.

Test Plan:
- **Load + unload.** Reset, `host_load`, then 20 words 0..3 repeating with `host_wvalid` held high. Then `host_unload` with `host_rready`=1 → 20 words 0,1,2,3,0,… on consecutive cycles; `busy` falls after the last word.
- **Unload backpressure.** During unload, toggle `host_rready` 1,0,0,1 → no word lost or duplicated; `host_rdata` stable while stalled.
- **Run.** `host_run` → `eng_start` high for exactly 1 cycle. Engine writes 0xA to addr 7, then reads addr 7 → `data_out`=0xA one cycle after `rd_en`. Same-cycle write 0x5 and read of addr 3 → `data_out`=0x5. `eng_done` → `busy`=0.
- **Illegal accesses.**
  - `wr_en` to addr 2 while IDLE → a later unload shows the original value; `acc_err`=1.
  - In RUN, `rd_addr`=25 → `data_out`=0.
- **Reset mid-load.** Reset after 5 of 20 load words → IDLE, `busy`=0. A new `host_load` restarts at address 0.
- **Parity (macro defined).** Force one RAM bit flip at addr 4 via hierarchical access, then unload → `par_err` rises at word 4 and stays high.

Source files
------------

// File: rtl/systemizer_pkg.sv
// systemizer_pkg: shared types and constants for the systemizer matrix memory.
//   mem_state_t  - memory-side sequencer states
//   Def*         - default word width, depth and address width
//   even_parity  - even-parity bit of a (zero-extended) word
package systemizer_pkg;

  localparam int unsigned DefDataW = 4;
  localparam int unsigned DefDepth = 20;
  localparam int unsigned DefAddrW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    UNLOAD = 2'd3
  } mem_state_t;

  // Callers zero-extend narrower words; zeros do not change the parity.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/systemizer_ram.sv
// systemizer_ram: single-clock word RAM, one write port and one synchronous read port.
//   clk         - clock
//   we/waddr    - write strobe / address, wdata - write word
//   re/raddr    - read enable / address; rdata updates on the edge after re, holds otherwise
// Reads of the address being written in the same cycle return the new word (write-first).
// Contents are not reset.
module systemizer_ram #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 20,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/systemizer_mem.sv
// systemizer_mem: responder memory for the systemizer plus host load/run/unload sequencer.
//   clk, rst                        - clock, asynchronous active-high reset
//   rd_en/rd_addr -> data_out       - engine read, one-cycle latency, holds when idle
//   wr_en/wr_addr/data_in           - engine write
//   eng_start / eng_done            - engine start pulse out, done pulse in
//   host_load/host_wdata/host_wvalid- stream DEPTH words into RAM
//   host_run                        - start the engine
//   host_unload/host_rdata/host_rvalid/host_rready - stream RAM out, valid/ready
//   busy                            - sequencer not IDLE
//   acc_err                         - sticky: illegal engine access
//   par_err                         - sticky parity error (0 unless SYSTEMIZER_MEM_PARITY_EN)
// Optional build macro: SYSTEMIZER_MEM_PARITY_EN adds a stored even-parity bit per word.
module systemizer_mem
  import systemizer_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic              host_load,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_wvalid,
  input  logic              host_run,
  input  logic              host_unload,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              host_rready,
  output logic              busy,
  output logic              acc_err,
  output logic              par_err
);

  // One extra bit so the counter can hold DEPTH itself ("all words issued").
  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] LastC  = CntW'(DEPTH - 1);
`ifdef SYSTEMIZER_MEM_PARITY_EN
  localparam int unsigned WordW = DATA_W + 1;
`else
  localparam int unsigned WordW = DATA_W;
`endif

  mem_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              eng_start_q, eng_start_d;
  logic              acc_err_q, acc_err_d;
  logic [DATA_W-1:0] data_hold_q, data_hold_d;
  logic              eng_rd_q, eng_rd_d;     // in-range engine read landed in RAM output
  logic              eng_oor_q, eng_oor_d;   // out-of-range engine read: present zero
  logic              inflight_q, inflight_d; // unload read landed in RAM output
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] wr_word;
  logic [WordW-1:0]  ram_wdata, ram_rdata;
  logic [DATA_W-1:0] ram_word;

  logic       rd_in, wr_in, pop, issue, unload_last;
  logic [1:0] occ_next;

  assign rd_in    = ({1'b0, rd_addr} < DepthC);
  assign wr_in    = ({1'b0, wr_addr} < DepthC);
  assign ram_word = ram_rdata[DATA_W-1:0];

  // Unload buffer: output register + skid register + one read in flight.
  // A read is issued only if its word is guaranteed a slot, which sustains one word per
  // cycle under steady ready and never overruns under backpressure.
  assign pop         = out_valid_q & host_rready;
  assign occ_next    = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(inflight_q) - 2'(pop);
  assign issue       = (state_q == UNLOAD) && (cnt_q < DepthC) && (occ_next < 2'd2);
  assign unload_last = pop && (cnt_q == DepthC) && !skid_valid_q && !inflight_q;

  // RAM port ownership by state.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    wr_word   = '0;
    ram_re    = 1'b0;
    ram_raddr = '0;
    case (state_q)
      LOAD: begin
        ram_we    = host_wvalid;
        ram_waddr = cnt_q[ADDR_W-1:0];
        wr_word   = host_wdata;
      end
      RUN: begin
        ram_we    = wr_en & wr_in;
        ram_waddr = wr_addr;
        wr_word   = data_in;
        ram_re    = rd_en & rd_in;
        ram_raddr = rd_addr;
      end
      UNLOAD: begin
        ram_re    = issue;
        ram_raddr = cnt_q[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

`ifdef SYSTEMIZER_MEM_PARITY_EN
  assign ram_wdata = {even_parity(32'(wr_word)), wr_word};
`else
  assign ram_wdata = wr_word;
`endif

  systemizer_ram #(
    .WIDTH  (WordW),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // data_out is the fresh RAM word after an engine read, zero after an out-of-range read,
  // otherwise the held previous value (the RAM output is shared with unload).
  always_comb begin
    if (eng_rd_q) begin
      data_out = ram_word;
    end else if (eng_oor_q) begin
      data_out = '0;
    end else begin
      data_out = data_hold_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    eng_start_d  = 1'b0;
    acc_err_d    = acc_err_q;
    data_hold_d  = data_out;
    eng_rd_d     = (state_q == RUN) & rd_en & rd_in;
    eng_oor_d    = rd_en & ~rd_in;
    inflight_d   = issue;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (((rd_en | wr_en) && (state_q != RUN)) || (rd_en && !rd_in) || (wr_en && !wr_in)) begin
      acc_err_d = 1'b1;
    end

    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = inflight_q;
        skid_data_d  = inflight_q ? ram_word : skid_data_q;
      end else begin
        out_valid_d  = inflight_q;
        out_data_d   = inflight_q ? ram_word : out_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (inflight_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ram_word;
    end

    case (state_q)
      IDLE: begin
        if (host_load) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (host_run) begin
          state_d     = RUN;
          eng_start_d = 1'b1;
        end else if (host_unload) begin
          state_d = UNLOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (host_wvalid) begin
          if (cnt_q == LastC) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      RUN: begin
        if (eng_done) begin
          state_d = IDLE;
        end
      end
      UNLOAD: begin
        if (issue) begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (unload_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      eng_start_q  <= 1'b0;
      acc_err_q    <= 1'b0;
      data_hold_q  <= '0;
      eng_rd_q     <= 1'b0;
      eng_oor_q    <= 1'b0;
      inflight_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      eng_start_q  <= eng_start_d;
      acc_err_q    <= acc_err_d;
      data_hold_q  <= data_hold_d;
      eng_rd_q     <= eng_rd_d;
      eng_oor_q    <= eng_oor_d;
      inflight_q   <= inflight_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef SYSTEMIZER_MEM_PARITY_EN
  logic par_err_q, par_err_d;

  // Stored word including its parity bit must have even overall parity.
  always_comb begin
    par_err_d = par_err_q;
    if ((eng_rd_q || inflight_q) && even_parity(32'(ram_rdata))) begin
      par_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign eng_start   = eng_start_q;
  assign busy        = (state_q != IDLE);
  assign acc_err     = acc_err_q;
  assign host_rvalid = out_valid_q;
  assign host_rdata  = out_data_q;

endmodule

// File: tb/tb_systemizer_mem.sv
// tb_systemizer_mem: scoreboard bench for systemizer_mem. Stimulus pushes expected unload
// words and engine read data into queues; a negedge monitor pops and compares.
module tb_systemizer_mem;

  localparam int unsigned DW = 4;
  localparam int unsigned DP = 20;
  localparam int unsigned AW = 5;

  logic          clk, rst;
  logic          rd_en, wr_en, eng_done, eng_start;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] data_out, data_in, host_wdata, host_rdata;
  logic          host_load, host_wvalid, host_run, host_unload, host_rvalid, host_rready;
  logic          busy, acc_err, par_err;

  systemizer_mem #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .ADDR_W (AW)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .data_out    (data_out),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .data_in     (data_in),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .host_load   (host_load),
    .host_wdata  (host_wdata),
    .host_wvalid (host_wvalid),
    .host_run    (host_run),
    .host_unload (host_unload),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .host_rready (host_rready),
    .busy        (busy),
    .acc_err     (acc_err),
    .par_err     (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_xfer, first_cyc, last_cyc;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] eng_q[$];
  logic [DW-1:0] model [DP];
  logic          rd_seen = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc++;
    rd_seen <= rd_en & ~rst;
  end

  // Monitor: engine read data, unload transfers, stall stability.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (rd_seen) begin
        checks++;
        if (eng_q.size() == 0) begin
          failures++;
          $display("FAIL eng_read unexpected data_out=%0h required=none", data_out);
        end else begin
          e = eng_q.pop_front();
          if (data_out !== e) begin
            failures++;
            $display("FAIL eng_read data_out=%0h required=%0h", data_out, e);
          end
        end
      end
      if (stall_prev) begin
        checks++;
        if (!host_rvalid || host_rdata !== stall_data) begin
          failures++;
          $display("FAIL unload_stall rvalid=%0b rdata=%0h required rvalid=1 rdata=%0h",
                   host_rvalid, host_rdata, stall_data);
        end
      end
      if (host_rvalid && host_rready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unload_word extra rdata=%0h required=none", host_rdata);
        end else begin
          e = exp_q.pop_front();
          if (host_rdata !== e) begin
            failures++;
            $display("FAIL unload_word index=%0d rdata=%0h required=%0h", n_xfer, host_rdata, e);
          end
        end
        if (n_xfer == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_xfer++;
      end
      stall_prev = host_rvalid & ~host_rready;
      stall_data = host_rdata;
    end
  end

  function automatic logic [DW-1:0] load_val(input int kind, input int i);
    if (kind == 0) return DW'(i % 4);
    return DW'((3 * i + 1) % 16);
  endfunction

  task automatic load_all(input int kind);
    host_load = 1'b1;
    tick();
    host_load = 1'b0;
    for (int i = 0; i < DP; i++) begin
      host_wvalid = 1'b1;
      host_wdata  = load_val(kind, i);
      model[i]    = load_val(kind, i);
      if (i == 10) check("load_busy", 32'(busy), 32'd1);
      tick();
    end
    host_wvalid = 1'b0;
    check("load_done_busy", 32'(busy), 32'd0);
  endtask

  task automatic unload_all(input bit bp);
    logic [3:0] pat;
    int k;
    pat = 4'b1001;  // ready sequence 1,0,0,1 (bit 0 first)
    for (int i = 0; i < DP; i++) exp_q.push_back(model[i]);
    n_xfer = 0;
    host_rready = 1'b1;
    host_unload = 1'b1;
    tick();
    host_unload = 1'b0;
    if (!bp) begin
      check("unload_lat0", 32'(host_rvalid), 32'd0);
      tick();
      check("unload_lat1", 32'(host_rvalid), 32'd0);
      tick();
      check("unload_lat2", 32'(host_rvalid), 32'd1);
    end
    k = 0;
    while (busy && k < 200) begin
      if (bp) host_rready = pat[k % 4];
      tick();
      k++;
    end
    host_rready = 1'b0;
    check("unload_timeout", 32'(k < 200), 32'd1);
    check("unload_count", 32'(n_xfer), 32'(DP));
    check("unload_left", 32'(exp_q.size()), 32'd0);
    check("unload_rvalid_end", 32'(host_rvalid), 32'd0);
    if (!bp) check("unload_gapless", 32'(last_cyc - first_cyc), 32'(DP - 1));
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; data_in = '0; eng_done = 1'b0;
    host_load = 1'b0; host_wdata = '0; host_wvalid = 1'b0; host_run = 1'b0;
    host_unload = 1'b0; host_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_rdata", 32'(host_rdata), 32'd0);
    check("rst_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acc_err", 32'(acc_err), 32'd0);
    rst = 1'b0;
    tick();

    // Load 0..3 repeating, unload at full rate.
    load_all(0);
    unload_all(1'b0);
    check("acc_err_clean", 32'(acc_err), 32'd0);

    // Engine write while IDLE is dropped and flagged.
    wr_en = 1'b1; wr_addr = AW'(2); data_in = 4'hF;
    tick();
    wr_en = 1'b0;
    check("idle_wr_acc_err", 32'(acc_err), 32'd1);

    // Run: start pulse, write/read, write-first, out-of-range read, hold, done.
    host_run = 1'b1;
    tick();
    host_run = 1'b0;
    check("run_start_hi", 32'(eng_start), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    tick();
    check("run_start_lo", 32'(eng_start), 32'd0);
    wr_en = 1'b1; wr_addr = AW'(7); data_in = 4'hA; model[7] = 4'hA;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = AW'(25); eng_q.push_back(4'h0);
    tick();
    rd_addr = AW'(7); eng_q.push_back(4'hA);
    tick();
    wr_en = 1'b1; wr_addr = AW'(3); data_in = 4'h5; model[3] = 4'h5;
    rd_addr = AW'(3); eng_q.push_back(4'h5);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    check("run_data_hold", 32'(data_out), 32'h5);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("run_done_busy", 32'(busy), 32'd0);
    check("eng_q_empty", 32'(eng_q.size()), 32'd0);

    // Unload under backpressure; addr 2 must still hold its loaded value.
    unload_all(1'b1);

    // Reset after 5 of 20 load words.
    host_load = 1'b1;
    tick();
    host_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      host_wvalid = 1'b1; host_wdata = 4'hE; model[i] = 4'hE;
      tick();
    end
    host_wvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("midload_busy", 32'(busy), 32'd0);
    check("midload_acc_err", 32'(acc_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    unload_all(1'b0);
    load_all(1);
    unload_all(1'b0);

`ifdef SYSTEMIZER_MEM_PARITY_EN
    check("par_err_clean", 32'(par_err), 32'd0);
    u_dut.u_ram.mem_q[4] = u_dut.u_ram.mem_q[4] ^ 5'b00001;
    model[4] = model[4] ^ 4'h1;
    unload_all(1'b0);
    check("par_err_set", 32'(par_err), 32'd1);
    tick();
    check("par_err_sticky", 32'(par_err), 32'd1);
`else
    check("par_err_tied", 32'(par_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
